// File: rtl/i2c_target_pkg.sv
// rtl/i2c_target_pkg.sv - shared state enum and bus level constants for the I2C target
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_RX,
      ST_RX_ACK,
      ST_TX,
      ST_TX_ACK,
      ST_WAIT_STOP
   } i2c_target_state_e;

   localparam logic I2C_RW_WRITE = 1'b0;
   localparam logic I2C_RW_READ  = 1'b1;
   localparam logic I2C_ACK      = 1'b0;
   localparam logic I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_target_if.sv
// rtl/i2c_target_if.sv - bus pins and host handshake of the I2C target
interface i2c_target_if;

   logic       i_sda;
   logic       i_scl;
   logic       o_sda_drive;
   logic       o_scl_drive;
   logic       o_busy;
   logic       o_start;
   logic       o_stop;
   logic       o_rx_valid;
   logic [7:0] o_rx_data;
   logic       i_rx_ack;
   logic       o_tx_req;
   logic       i_tx_valid;
   logic [7:0] i_tx_data;
   logic       o_tx_nack;

   modport slave (
      input  i_sda, i_scl, i_rx_ack, i_tx_valid, i_tx_data,
      output o_sda_drive, o_scl_drive, o_busy, o_start, o_stop,
      output o_rx_valid, o_rx_data, o_tx_req, o_tx_nack
   );

   modport master (
      output i_sda, i_scl, i_rx_ack, i_tx_valid, i_tx_data,
      input  o_sda_drive, o_scl_drive, o_busy, o_start, o_stop,
      input  o_rx_valid, o_rx_data, o_tx_req, o_tx_nack
   );

endinterface

// File: rtl/i2c_target_bus_sync.sv
// rtl/i2c_target_bus_sync.sv - SDA/SCL synchronizer with SCL edge and START/STOP detection
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic sda_pin,
   input  logic scl_pin,
   output logic scl,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   logic [SYNC_STAGES-1:0] sda_sync;
   logic [SYNC_STAGES-1:0] scl_sync;
   logic                   sda_prev;
   logic                   scl_prev;

   // Reset to the idle-high bus level so leaving reset never fakes a START.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sda_sync <= '1;
         scl_sync <= '1;
         sda_prev <= 1'b1;
         scl_prev <= 1'b1;
      end else begin
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_pin};
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_pin};
         sda_prev <= sda_sync[SYNC_STAGES-1];
         scl_prev <= scl_sync[SYNC_STAGES-1];
      end
   end

   assign sda      = sda_sync[SYNC_STAGES-1];
   assign scl      = scl_sync[SYNC_STAGES-1];
   assign scl_rise = scl & ~scl_prev;
   assign scl_fall = ~scl & scl_prev;
   assign start    = scl & scl_prev & sda_prev & ~sda;
   assign stop     = scl & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - single-address I2C target; I2C_TARGET_STRETCH_EN enables SCL stretching on tx underflow
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] ADDR        = 7'h33,
   parameter int         SYNC_STAGES = 2
) (
   input  logic         i_clk,
   input  logic         i_rst,
   i2c_target_if.slave  bus
);

   logic scl, sda, scl_rise, scl_fall, bus_start, bus_stop;
   logic unused_scl;

   i2c_target_state_e state;
   logic [2:0] cnt;
   logic [7:0] shift;
   logic       rw;
   logic       phase;
   logic       rx_ack_q;
   logic       sda_drive;
   logic       busy;
   logic       start_p;
   logic       stop_p;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       tx_req;
   logic       tx_nack;
   logic       load_now;
`ifdef I2C_TARGET_STRETCH_EN
   logic       scl_drive;
   logic       stretch;
`endif

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .sda_pin  (bus.i_sda),
      .scl_pin  (bus.i_scl),
      .scl      (scl),
      .sda      (sda),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (bus_start),
      .stop     (bus_stop)
   );

   assign unused_scl = scl;

   // The fall that ends an ACK'd slot of a read is where the next byte is fetched.
   assign load_now = scl_fall && phase &&
                     ((state == ST_ADDR_ACK && rw == I2C_RW_READ) || state == ST_TX_ACK);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= ST_IDLE;
         cnt       <= 3'd0;
         shift     <= 8'h00;
         rw        <= I2C_RW_WRITE;
         phase     <= 1'b0;
         rx_ack_q  <= 1'b0;
         sda_drive <= 1'b1;
         busy      <= 1'b0;
         start_p   <= 1'b0;
         stop_p    <= 1'b0;
         rx_valid  <= 1'b0;
         rx_data   <= 8'h00;
         tx_req    <= 1'b0;
         tx_nack   <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
         scl_drive <= 1'b1;
         stretch   <= 1'b0;
`endif
      end else begin
         start_p  <= 1'b0;
         stop_p   <= 1'b0;
         rx_valid <= 1'b0;
         tx_req   <= 1'b0;
         tx_nack  <= 1'b0;
         if (bus_stop) begin
            state     <= ST_IDLE;
            sda_drive <= 1'b1;
            busy      <= 1'b0;
            phase     <= 1'b0;
            stop_p    <= 1'b1;
`ifdef I2C_TARGET_STRETCH_EN
            scl_drive <= 1'b1;
            stretch   <= 1'b0;
`endif
         end else if (bus_start) begin
            state     <= ST_ADDR;
            cnt       <= 3'd0;
            sda_drive <= 1'b1;
            phase     <= 1'b0;
            start_p   <= 1'b1;
`ifdef I2C_TARGET_STRETCH_EN
            scl_drive <= 1'b1;
            stretch   <= 1'b0;
`endif
         end else begin
            case (state)
               ST_ADDR: begin
                  if (scl_rise) begin
                     shift <= {shift[6:0], sda};
                     cnt   <= cnt + 3'd1;
                     if (cnt == 3'd7) begin
                        if (shift[6:0] == ADDR) begin
                           state  <= ST_ADDR_ACK;
                           busy   <= 1'b1;
                           rw     <= sda;
                           phase  <= 1'b0;
                           tx_req <= (sda == I2C_RW_READ);
                        end else begin
                           state <= ST_WAIT_STOP;
                        end
                     end
                  end
               end
               ST_ADDR_ACK: begin
                  if (scl_fall) begin
                     if (!phase) begin
                        sda_drive <= I2C_ACK;
                        phase     <= 1'b1;
                     end else begin
                        sda_drive <= 1'b1;
                        phase     <= 1'b0;
                        cnt       <= 3'd0;
                        state     <= (rw == I2C_RW_WRITE) ? ST_RX : ST_TX;
                     end
                  end
               end
               ST_RX: begin
                  if (scl_rise) begin
                     shift <= {shift[6:0], sda};
                     cnt   <= cnt + 3'd1;
                     if (cnt == 3'd7) begin
                        rx_data  <= {shift[6:0], sda};
                        rx_valid <= 1'b1;
                        rx_ack_q <= bus.i_rx_ack;
                        phase    <= 1'b0;
                        state    <= ST_RX_ACK;
                     end
                  end
               end
               ST_RX_ACK: begin
                  if (scl_fall) begin
                     if (!phase) begin
                        if (rx_ack_q) begin
                           sda_drive <= I2C_ACK;
                           phase     <= 1'b1;
                        end else begin
                           state <= ST_WAIT_STOP;
                        end
                     end else begin
                        sda_drive <= 1'b1;
                        phase     <= 1'b0;
                        state     <= ST_RX;
                     end
                  end
               end
               ST_TX: begin
`ifdef I2C_TARGET_STRETCH_EN
                  if (stretch) begin
                     if (bus.i_tx_valid) begin
                        shift     <= bus.i_tx_data;
                        sda_drive <= bus.i_tx_data[7];
                        scl_drive <= 1'b1;
                        stretch   <= 1'b0;
                     end
                  end else
`endif
                  if (scl_rise) begin
                     cnt <= cnt + 3'd1;
                  end else if (scl_fall) begin
                     // cnt has wrapped to 0 after the 8th rise: hand SDA back for the ACK slot.
                     if (cnt == 3'd0) begin
                        sda_drive <= 1'b1;
                        phase     <= 1'b0;
                        state     <= ST_TX_ACK;
                     end else begin
                        sda_drive <= shift[6];
                        shift     <= {shift[6:0], 1'b1};
                     end
                  end
               end
               ST_TX_ACK: begin
                  if (scl_rise && !phase) begin
                     if (sda == I2C_ACK) begin
                        tx_req <= 1'b1;
                        phase  <= 1'b1;
                     end else begin
                        tx_nack <= 1'b1;
                        state   <= ST_WAIT_STOP;
                     end
                  end else if (scl_fall && phase) begin
                     phase <= 1'b0;
                     cnt   <= 3'd0;
                     state <= ST_TX;
                  end
               end
               default: ;
            endcase
            if (load_now) begin
               if (bus.i_tx_valid) begin
                  shift     <= bus.i_tx_data;
                  sda_drive <= bus.i_tx_data[7];
               end else begin
`ifdef I2C_TARGET_STRETCH_EN
                  scl_drive <= 1'b0;
                  stretch   <= 1'b1;
                  sda_drive <= 1'b1;
`else
                  shift     <= 8'hFF;
                  sda_drive <= 1'b1;
`endif
               end
            end
         end
      end
   end

   assign bus.o_sda_drive = sda_drive;
`ifdef I2C_TARGET_STRETCH_EN
   assign bus.o_scl_drive = scl_drive;
`else
   assign bus.o_scl_drive = 1'b1;
`endif
   assign bus.o_busy      = busy;
   assign bus.o_start     = start_p;
   assign bus.o_stop      = stop_p;
   assign bus.o_rx_valid  = rx_valid;
   assign bus.o_rx_data   = rx_data;
   assign bus.o_tx_req    = tx_req;
   assign bus.o_tx_nack   = tx_nack;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed bench driving an open-drain I2C initiator model against i2c_target
module tb_i2c_target;
   import i2c_pkg::*;

   localparam int Q = 50;

   typedef struct {
      logic [7:0]        addr_byte;
      logic [7:0]        data;
      logic              rx_ack;
      logic              exp_aack;
      logic              exp_dack;
      int                exp_rx;
      i2c_target_state_e exp_state;
      logic              exp_busy;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic m_sda = 1'b1;
   logic m_scl = 1'b1;
   logic tx_valid = 1'b1;
   logic rx_ack = 1'b1;
   logic [7:0] tx_list [4];
   logic [7:0] last_rx = 8'h00;
   int n_checks = 0;
   int n_fail = 0;
   int n_start = 0, n_stop = 0, n_rx = 0, n_txreq = 0, n_txnack = 0;
   int n_sda_low = 0, n_scl_low = 0;
   vec_t vecs [7];

   i2c_target_if bus();

   wire sda_bus = m_sda & bus.o_sda_drive;
   wire scl_bus = m_scl & bus.o_scl_drive;

   assign bus.i_sda      = sda_bus;
   assign bus.i_scl      = scl_bus;
   assign bus.i_rx_ack   = rx_ack;
   assign bus.i_tx_valid = tx_valid;
   assign bus.i_tx_data  = tx_list[2'(n_txreq - 1)];

   i2c_target dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.o_start)     n_start++;
      if (bus.o_stop)      n_stop++;
      if (bus.o_tx_req)    n_txreq++;
      if (bus.o_tx_nack)   n_txnack++;
      if (!bus.o_sda_drive) n_sda_low++;
      if (!bus.o_scl_drive) n_scl_low++;
      if (bus.o_rx_valid) begin
         n_rx++;
         last_rx = bus.o_rx_data;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic scl_high();
      int n = 0;
      m_scl = 1'b1;
      while (scl_bus !== 1'b1 && n < 400) begin
         #10;
         n++;
      end
      if (n >= 400) begin
         n_checks++;
         n_fail++;
         $display("FAIL scl_release: SCL still low after %0d cycles, required high", n);
      end
   endtask

   task automatic clock_bit(input logic b, output logic r);
      m_sda = b;
      #Q;
      scl_high();
      #Q;
      r = sda_bus;
      #Q;
      m_scl = 1'b0;
      #Q;
   endtask

   task automatic i2c_start();
      m_sda = 1'b1;
      #Q;
      scl_high();
      #Q;
      m_sda = 1'b0;
      #Q;
      m_scl = 1'b0;
      #Q;
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0;
      #Q;
      scl_high();
      #Q;
      m_sda = 1'b1;
      #Q;
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
      clock_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic ack_in, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, r);
         d[i] = r;
      end
      clock_bit(ack_in, r);
   endtask

   initial begin
      logic ack;
      logic [7:0] d;
      int b_start, b_stop, b_rx, b_txreq, b_txnack, b_sda, b_scl;

      foreach (tx_list[i]) tx_list[i] = 8'h00;
      vecs[0] = '{8'h66, 8'h95, 1'b1, 1'b0, 1'b0, 1, ST_RX,        1'b1};
      vecs[1] = '{8'h68, 8'h00, 1'b1, 1'b1, 1'b1, 0, ST_WAIT_STOP, 1'b0};
      vecs[2] = '{8'h66, 8'h55, 1'b0, 1'b0, 1'b1, 1, ST_WAIT_STOP, 1'b1};
      vecs[3] = '{8'h64, 8'hAA, 1'b1, 1'b1, 1'b1, 0, ST_WAIT_STOP, 1'b0};
      vecs[4] = '{8'hE6, 8'hAA, 1'b1, 1'b1, 1'b1, 0, ST_WAIT_STOP, 1'b0};
      vecs[5] = '{8'h66, 8'h00, 1'b1, 1'b0, 1'b0, 1, ST_RX,        1'b1};
      vecs[6] = '{8'h66, 8'hFF, 1'b1, 1'b0, 1'b0, 1, ST_RX,        1'b1};

      repeat (3) @(posedge clk);
      #3;
      check("rst_sda_drive", bus.o_sda_drive, 1);
      check("rst_scl_drive", bus.o_scl_drive, 1);
      check("rst_busy", bus.o_busy, 0);
      check("rst_pulses", {bus.o_start, bus.o_stop, bus.o_rx_valid, bus.o_tx_req, bus.o_tx_nack}, 0);
      check("rst_rx_data", bus.o_rx_data, 8'h00);
      check("rst_state", 32'(dut.state), 32'(ST_IDLE));
      rst = 1'b0;
      #200;

      for (int k = 0; k < 7; k++) begin
         b_start = n_start; b_stop = n_stop; b_rx = n_rx; b_sda = n_sda_low;
         rx_ack = vecs[k].rx_ack;
         i2c_start();
         write_byte(vecs[k].addr_byte, ack);
         check($sformatf("v%0d_addr_ack", k), ack, vecs[k].exp_aack);
         if (vecs[k].exp_aack) begin
            check($sformatf("v%0d_sda_never_low", k), n_sda_low - b_sda, 0);
         end else begin
            write_byte(vecs[k].data, ack);
            check($sformatf("v%0d_data_ack", k), ack, vecs[k].exp_dack);
         end
         check($sformatf("v%0d_state", k), 32'(dut.state), 32'(vecs[k].exp_state));
         check($sformatf("v%0d_busy", k), bus.o_busy, vecs[k].exp_busy);
         check($sformatf("v%0d_rx_count", k), n_rx - b_rx, vecs[k].exp_rx);
         if (vecs[k].exp_rx != 0) check($sformatf("v%0d_rx_data", k), last_rx, vecs[k].data);
         i2c_stop();
         check($sformatf("v%0d_start_count", k), n_start - b_start, 1);
         check($sformatf("v%0d_stop_count", k), n_stop - b_stop, 1);
         check($sformatf("v%0d_busy_after_stop", k), bus.o_busy, 0);
         check($sformatf("v%0d_state_idle", k), 32'(dut.state), 32'(ST_IDLE));
      end
      rx_ack = 1'b1;

      // Read of two bytes: ACK the first, NACK the last.
      b_txreq = n_txreq; b_txnack = n_txnack;
      tx_list[2'(b_txreq)]     = 8'hA5;
      tx_list[2'(b_txreq + 1)] = 8'h3C;
      i2c_start();
      write_byte(8'h67, ack);
      check("rd_addr_ack", ack, 0);
      check("rd_txreq_after_addr", n_txreq - b_txreq, 1);
      read_byte(1'b0, d);
      check("rd_byte0", d, 8'hA5);
      read_byte(1'b1, d);
      check("rd_byte1", d, 8'h3C);
      check("rd_txreq_total", n_txreq - b_txreq, 2);
      check("rd_txnack", n_txnack - b_txnack, 1);
      check("rd_state", 32'(dut.state), 32'(ST_WAIT_STOP));
      check("rd_busy", bus.o_busy, 1);
      i2c_stop();
      check("rd_busy_after_stop", bus.o_busy, 0);

      // Write then repeated START into a read.
      b_start = n_start; b_rx = n_rx; b_txreq = n_txreq; b_txnack = n_txnack;
      tx_list[2'(b_txreq)] = 8'hC3;
      i2c_start();
      write_byte(8'h66, ack);
      write_byte(8'h12, ack);
      check("rs_data_ack", ack, 0);
      check("rs_rx_data", last_rx, 8'h12);
      i2c_start();
      check("rs_start_count", n_start - b_start, 2);
      check("rs_state_addr", 32'(dut.state), 32'(ST_ADDR));
      write_byte(8'h67, ack);
      check("rs_addr_ack", ack, 0);
      read_byte(1'b1, d);
      check("rs_read_byte", d, 8'hC3);
      check("rs_rx_count", n_rx - b_rx, 1);
      check("rs_txnack", n_txnack - b_txnack, 1);
      i2c_stop();

      // Underflow at the loading fall.
      b_txreq = n_txreq; b_scl = n_scl_low;
      tx_list[2'(b_txreq)] = 8'h5A;
      tx_valid = 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
      fork
         begin
            int w = 0;
            while (bus.o_scl_drive !== 1'b0 && w < 2000) begin
               @(negedge clk);
               w++;
            end
            repeat (50) @(negedge clk);
            tx_valid = 1'b1;
         end
      join_none
`endif
      i2c_start();
      write_byte(8'h67, ack);
      check("uf_addr_ack", ack, 0);
      read_byte(1'b1, d);
      i2c_stop();
`ifdef I2C_TARGET_STRETCH_EN
      check("uf_stretched_byte", d, 8'h5A);
      n_checks++;
      if (n_scl_low - b_scl < 50 || n_scl_low - b_scl > 52) begin
         n_fail++;
         $display("FAIL uf_stretch_cycles: got %0d, expected 50..52", n_scl_low - b_scl);
      end
`else
      check("uf_byte_ff", d, 8'hFF);
      check("uf_no_stretch", n_scl_low - b_scl, 0);
`endif
      tx_valid = 1'b1;

      // Reset while the target holds the address ACK.
      i2c_start();
      for (int i = 7; i >= 0; i--) begin
         logic r;
         logic [7:0] a;
         a = 8'h66;
         clock_bit(a[i], r);
      end
      m_sda = 1'b1;
      #Q;
      check("rs_ack_driven", bus.o_sda_drive, 0);
      b_start = n_start; b_stop = n_stop; b_rx = n_rx; b_txreq = n_txreq; b_txnack = n_txnack;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid_sda_release", bus.o_sda_drive, 1);
      @(negedge clk);
      rst = 1'b0;
      #3;
      scl_high();
      #Q;
      #Q;
      m_scl = 1'b0;
      #Q;
      write_byte(8'hAA, ack);
      check("post_rst_no_ack", ack, 1);
      check("post_rst_no_pulses",
            (n_start - b_start) + (n_stop - b_stop) + (n_rx - b_rx) + (n_txreq - b_txreq) + (n_txnack - b_txnack), 0);
      check("post_rst_state", 32'(dut.state), 32'(ST_IDLE));
      check("post_rst_busy", bus.o_busy, 0);
      i2c_start();
      check("post_rst_start", n_start - b_start, 1);
      write_byte(8'h66, ack);
      check("post_rst_addr_ack", ack, 0);
      write_byte(8'h3C, ack);
      i2c_stop();
      check("post_rst_rx_data", last_rx, 8'h3C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (responder) for a single 7-bit address, sitting on the same open-drain SDA/SCL pair as the `i2c_byte_gen` / `i2c_bit_gen` initiator chain. It detects START, repeated START and STOP, and matches the address byte. On writes it acknowledges and delivers received bytes. On reads it requests and shifts out transmit bytes. It is used as an on-chip bus model and as the peripheral-side endpoint for the thermal camera's control path.

## Interface
Parameters:
- `ADDR`, 7'h33: 7-bit target address.
- `SYNC_STAGES`, 2: flip-flop synchronizer depth on `i_sda` and `i_scl`, minimum 2.

Ports:
- `i_clk`, in, 1: system clock. Must run at 10× or more of the SCL frequency.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_sda`, in, 1: SDA bus level.
- `i_scl`, in, 1: SCL bus level.
- `o_sda_drive`, out, 1: 1 releases SDA (high-Z), 0 pulls it low.
- `o_scl_drive`, out, 1: 1 releases SCL, 0 pulls it low. Used for clock stretching.
- `o_busy`, out, 1: high from a START addressed to this target until STOP.
- `o_start`, out, 1: one-cycle pulse on every START or repeated START.
- `o_stop`, out, 1: one-cycle pulse on STOP.
- `o_rx_valid`, out, 1: one-cycle pulse when a write data byte is complete.
- `o_rx_data`, out, 8: received byte. Valid when `o_rx_valid` is high and held until the next byte.
- `i_rx_ack`, in, 1: 1 ACKs the current write byte, 0 NACKs it.
- `o_tx_req`, out, 1: one-cycle pulse requesting the next read byte.
- `i_tx_valid`, in, 1: `i_tx_data` is valid.
- `i_tx_data`, in, 8: byte to transmit, MSB first.
- `o_tx_nack`, out, 1: one-cycle pulse when the initiator NACKs a read byte.

## Operation
- Bus events are computed on the synchronized `scl`/`sda`:
  - START: sda falls while scl is high.
  - STOP: sda rises while scl is high.
  - Bits are sampled on scl rise.
  - `o_sda_drive` changes only on a detected scl fall.
- FSM states: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
- IDLE → ADDR on START. A 3-bit counter is cleared and the shift register loads MSB first.
- ADDR: after the 8th rise, compare bits[7:1] with `ADDR`.
  - Match → ADDR_ACK and `o_busy`=1.
  - Mismatch → WAIT_STOP. SDA is never driven.
- ADDR_ACK:
  - Pull SDA low from the 8th fall to the 9th fall.
  - R/W=0 → RX.
  - R/W=1 → pulse `o_tx_req` on entry, then TX.
- RX: on the 8th rise, load `o_rx_data`, pulse `o_rx_valid`, and sample `i_rx_ack` in the same cycle. Then go to RX_ACK.
- RX_ACK:
  - Sampled ACK → pull SDA low from the 8th fall to the 9th fall, then return to RX.
  - Sampled NACK → leave SDA released, then WAIT_STOP.
- TX:
  - On the scl fall that ends the ACK, load `i_tx_data` into the shift register.
  - Drive each bit on scl fall. A 1 is sent by release.
  - Release SDA at the 8th fall, then go to TX_ACK.
- TX_ACK: sample SDA on the 9th rise.
  - Low → pulse `o_tx_req`, then TX.
  - High → pulse `o_tx_nack`, then WAIT_STOP.
- WAIT_STOP: SDA stays released. Leave on START (→ ADDR) or STOP (→ IDLE).
- Global priorities:
  - START in any state → ADDR, counter cleared, SDA released. This covers repeated START.
  - STOP in any state → IDLE, SDA/SCL released, `o_busy`=0.
  - START and STOP cannot coincide, because sda has a single edge.
- Data-byte underflow: if `i_tx_valid`=0 at the loading scl fall, behaviour depends on the Configuration macro.

## Timing
- Reset values:
  - `o_sda_drive`=1, `o_scl_drive`=1.
  - `o_busy`, `o_start`, `o_stop`, `o_rx_valid`, `o_tx_req`, `o_tx_nack` = 0.
  - `o_rx_data`=8'h00.
  - FSM in IDLE.
- Reset mid-transfer releases SDA/SCL on the first clock edge with `i_rst` high. After reset, traffic is ignored until the next START.
- Event detection latency is `SYNC_STAGES`+1 `i_clk` cycles after a bus pin edge. This applies to all pulses, SDA changes and sampling.
- `o_sda_drive` is updated in the same cycle that scl fall is detected. Hold time is therefore at least `SYNC_STAGES`+1 cycles.
- `o_tx_req` precedes the loading scl fall by at least half an SCL period. Host logic must present `i_tx_valid`/`i_tx_data` within that window.

## Configuration
- `I2C_TARGET_STRETCH_EN` defined: on underflow, pull SCL low (`o_scl_drive`=0) from the loading fall until `i_tx_valid`=1. Then load the byte and release SCL on the next cycle.
- `I2C_TARGET_STRETCH_EN` undefined: `o_scl_drive` is tied to 1, and underflow transmits 8'hFF.

## Structure
- Package `i2c_pkg` holds:
  - the `i2c_target_state_e` enum;
  - the `I2C_RW_READ`/`I2C_RW_WRITE` constants;
  - the ACK (0) and NACK (1) level constants.
- Sub-module `i2c_bus_sync`: `SYNC_STAGES` synchronizer plus edge detect. It outputs `scl`, `sda`, `scl_rise`, `scl_fall`, `start`, `stop`.

## Test plan
- Write: initiator `i2c_byte_gen` sends address 0x66 then 0x95 with `i_rx_ack`=1 → `o_start` pulse, ACK on both 9th clocks, `o_rx_valid` with `o_rx_data`=0x95, and `o_stop` at the end.
- Address mismatch: address byte 0x68 → SDA never low, initiator sees `o_wr_nack`, FSM in WAIT_STOP, `o_busy`=0.
- Read: address 0x67, `i_tx_data`=0xA5 then 0x3C, initiator ACKs then NACKs (`i_rd_last`) → initiator reads 0xA5 and 0x3C, two `o_tx_req` pulses, one `o_tx_nack`.
- Repeated START: write 0x66 + 0x12, repeated START, read 0x67 → second `o_start`, state ADDR, read byte correct, no spurious `o_rx_valid`.
- Data NACK: `i_rx_ack`=0 on byte 0x55 → SDA released on 9th clock, then WAIT_STOP until STOP.
- Reset during ADDR_ACK: `i_rst` raised while `o_sda_drive`=0 → `o_sda_drive`=1 one cycle later, and no output pulses until the next START. With `I2C_TARGET_STRETCH_EN`, hold `i_tx_valid`=0 for 50 cycles → SCL held low for 50 cycles, after which the byte is sent correctly.
